// File: rtl/vsync_decoder_pkg.sv
// ---------------------------------------------------------------------------
// vsync_decoder_pkg
//   Shared constants for the 640x480@60Hz vertical timing receive path and
//   the state encoding of the lock FSM. The timing generator uses the same
//   line constants, so both sides agree on frame geometry.
//
//   Contents:
//     VGA_*      vertical line constants of the 640x480 mode
//     VDEC_*     widths and lock depth used by the decoder
//     vdec_state_t  SEARCH=0, MEASURE=1, LOCKED=2
// ---------------------------------------------------------------------------
package vsync_decoder_pkg;

    localparam int VGA_LINES_TOTAL  = 525;
    localparam int VGA_PULSE_LINES  = 2;
    localparam int VGA_BP_LINES     = 35;
    localparam int VGA_VIS_END      = 515;

    localparam int VDEC_LOCK_FRAMES = 3;
    localparam int VDEC_CNT_BIT     = 10;
    localparam int VDEC_IDX_BIT     = 9;
    localparam int VDEC_PW_BIT      = 3;
    localparam int VDEC_GCNT_BIT    = 3;
    localparam int VDEC_ERRCNT_BIT  = 8;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } vdec_state_t;

endpackage

// File: rtl/vsync_decoder_rise_edge_det.sv
// ---------------------------------------------------------------------------
// rise_edge_det
//   One-register rising-edge detector for a level that is already
//   synchronous to clk. Shared by the vsync and hsync decoders.
//
//   Ports:
//     clk        in   clock
//     i_rst_n    in   asynchronous active-low reset
//     i_level    in   level to watch
//     o_level_q  out  level delayed by one cycle
//     o_rise     out  combinational: i_level high while the delayed copy is low
// ---------------------------------------------------------------------------
module rise_edge_det (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_level_q,
    output logic o_rise
);

    logic r_level_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_level_q = r_level_q;
    assign o_rise    = i_level & ~r_level_q;

endmodule

// File: rtl/vsync_decoder.sv
// ---------------------------------------------------------------------------
// vsync_decoder
//   Receive side of the 640x480@60Hz vertical timing. Counts line strobes
//   between vsync rising edges, checks frame length and vsync pulse width,
//   and declares lock after LOCK_FRAMES consecutive good frames. While
//   locked it regenerates the visible-line index and address enable for the
//   frame-buffer write path.
//
//   Ports:
//     clk          in   pixel clock
//     i_rst_n      in   asynchronous active-low reset
//     i_ven        in   one-cycle line strobe
//     i_vsync_enb  in   vsync level, active-high, synchronous to clk
//     o_locked     out  geometry verified
//     o_frame_en   out  one-cycle pulse after each frame start while locked
//     o_addr_enb   out  high on visible lines while locked
//     o_idx        out  visible line index, 0 outside the visible area
//     o_err        out  one-cycle pulse on a bad frame or a timeout
//     o_lines      out  line count of the last completed frame
//     o_err_cnt    out  saturating o_err pulse count (VSYNC_DEC_STATS_EN only)
//
//   Build option:
//     VSYNC_DEC_STATS_EN  adds o_err_cnt and its counter.
// ---------------------------------------------------------------------------
module vsync_decoder
    import vsync_decoder_pkg::*;
#(
    parameter int LINES_TOTAL = VGA_LINES_TOTAL,
    parameter int PULSE_LINES = VGA_PULSE_LINES,
    parameter int BP_LINES    = VGA_BP_LINES,
    parameter int VIS_END     = VGA_VIS_END,
    parameter int LOCK_FRAMES = VDEC_LOCK_FRAMES,
    parameter int CNT_BIT     = VDEC_CNT_BIT
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_ven,
    input  logic                    i_vsync_enb,
    output logic                    o_locked,
    output logic                    o_frame_en,
    output logic                    o_addr_enb,
    output logic [VDEC_IDX_BIT-1:0] o_idx,
    output logic                    o_err,
`ifdef VSYNC_DEC_STATS_EN
    output logic [VDEC_ERRCNT_BIT-1:0] o_err_cnt,
`endif
    output logic [CNT_BIT-1:0]      o_lines
);

    localparam int GCNT_LAST_I = LOCK_FRAMES - 1;

    localparam logic [CNT_BIT-1:0]       CNT_MAX   = '1;
    localparam logic [CNT_BIT-1:0]       CNT_NEAR  = CNT_MAX - 1'b1;
    localparam logic [CNT_BIT-1:0]       CNT_ONE   = {{(CNT_BIT-1){1'b0}}, 1'b1};
    localparam logic [CNT_BIT:0]         LEN_GOOD  = LINES_TOTAL[CNT_BIT:0];
    localparam logic [CNT_BIT-1:0]       BP_CNT    = BP_LINES[CNT_BIT-1:0];
    localparam logic [CNT_BIT-1:0]       VIS_CNT   = VIS_END[CNT_BIT-1:0];
    localparam logic [VDEC_PW_BIT-1:0]   PW_GOOD   = PULSE_LINES[VDEC_PW_BIT-1:0];
    localparam logic [VDEC_PW_BIT-1:0]   PW_MAX    = '1;
    localparam logic [VDEC_GCNT_BIT-1:0] GCNT_LAST = GCNT_LAST_I[VDEC_GCNT_BIT-1:0];

    logic                     w_vs_q;
    logic                     w_rise;
    logic [CNT_BIT:0]         w_len;
    logic [CNT_BIT-1:0]       w_len_sat;
    logic                     w_good;
    logic                     w_timeout;
    logic [VDEC_IDX_BIT-1:0]  w_idx;

    logic [CNT_BIT-1:0]       r_cnt;
    logic [VDEC_PW_BIT-1:0]   r_pw;
    vdec_state_t              r_state;
    logic [VDEC_GCNT_BIT-1:0] r_gcnt;
    logic                     r_err;
    logic                     r_frame_en;
    logic [CNT_BIT-1:0]       r_lines;

    rise_edge_det u_vs_edge (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_level   (i_vsync_enb),
        .o_level_q (w_vs_q),
        .o_rise    (w_rise)
    );

    // A strobe coinciding with the edge still belongs to the ending frame
    // for length purposes, while it also starts the new frame's count.
    assign w_len     = {1'b0, r_cnt} + {{CNT_BIT{1'b0}}, i_ven};
    assign w_len_sat = w_len[CNT_BIT] ? CNT_MAX : w_len[CNT_BIT-1:0];
    assign w_good    = (w_len == LEN_GOOD) && (r_pw == PW_GOOD);

    // Fires only on the strobe that drives cnt into saturation, so a stuck
    // vsync produces exactly one error pulse rather than one per line.
    assign w_timeout = ~w_rise & i_ven & (r_cnt == CNT_NEAR);

    // Line counter and vsync pulse-width counter. Both saturate so a missing
    // or stuck vsync can never make them wrap back into a plausible range.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_pw  <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= i_ven ? CNT_ONE : '0;
            end else if (i_ven && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (w_rise) begin
                r_pw <= '0;
            end else if (w_vs_q && i_ven && (r_pw != PW_MAX)) begin
                r_pw <= r_pw + 1'b1;
            end
        end
    end

    // Lock FSM with its registered outputs. The first edge after SEARCH only
    // opens a measurement window; the frame ending at it is of unknown
    // origin and is not judged. A timeout overrides any edge handling.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= SEARCH;
            r_gcnt     <= '0;
            r_err      <= 1'b0;
            r_frame_en <= 1'b0;
            r_lines    <= '0;
        end else begin
            r_err      <= 1'b0;
            r_frame_en <= 1'b0;

            if (w_rise) begin
                r_lines <= w_len_sat;
            end

            if (w_timeout) begin
                r_state <= SEARCH;
                r_gcnt  <= '0;
                r_err   <= 1'b1;
            end else if (w_rise) begin
                case (r_state)
                    SEARCH: begin
                        r_state <= MEASURE;
                        r_gcnt  <= '0;
                    end
                    MEASURE: begin
                        if (w_good) begin
                            if (r_gcnt == GCNT_LAST) begin
                                r_state <= LOCKED;
                                r_gcnt  <= '0;
                            end else begin
                                r_gcnt <= r_gcnt + 1'b1;
                            end
                        end else begin
                            r_gcnt <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        r_frame_en <= 1'b1;
                        if (!w_good) begin
                            r_state <= MEASURE;
                            r_gcnt  <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                        r_gcnt  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef VSYNC_DEC_STATS_EN
    logic [VDEC_ERRCNT_BIT-1:0] r_err_cnt;

    // Counts each error pulse once it is visible on o_err; holds at full scale.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (r_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    // Index arithmetic is done at output width; the modular result equals
    // the truncated full-width difference.
    assign w_idx      = r_cnt[VDEC_IDX_BIT-1:0] - BP_CNT[VDEC_IDX_BIT-1:0];

    assign o_locked   = (r_state == LOCKED);
    assign o_addr_enb = o_locked && (r_cnt >= BP_CNT) && (r_cnt < VIS_CNT);
    assign o_idx      = o_addr_enb ? w_idx : '0;
    assign o_err      = r_err;
    assign o_frame_en = r_frame_en;
    assign o_lines    = r_lines;

endmodule
